// File: rtl/ysyx_22040632_gpr_sb.sv
// ysyx_22040632_gpr_sb: general-purpose register file with a per-register scoreboard for in-order issue.
// Ports:
//   clk, rst                         clock and synchronous active-high reset
//   i_issue_valid / o_issue_ready    issue handshake; ready is low on any RAW/WAW hazard or during reset
//   i_issue_rs1/rs2/rd, i_issue_wen  source/destination indices and destination-write flag
//   o_rdata1/o_rdata2                combinational operand reads (with optional writeback forwarding)
//   i_wb_valid/i_wb_rd/i_wb_data     writeback port, clears the busy flag of wb_rd
//   o_busy_vec, o_pending_cnt        pending-write flags and their registered population count
//   o_wb_err                         sticky flag: writeback seen to a nonzero register that was not busy
module ysyx_22040632_gpr_sb #(
  parameter int XLEN = 64,
  parameter int NREG = 32,
  parameter int BYPASS = 1,
  localparam int AW = $clog2(NREG),
  localparam int CW = $clog2(NREG + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_issue_valid,
  output logic            o_issue_ready,
  input  logic [AW-1:0]   i_issue_rs1,
  input  logic [AW-1:0]   i_issue_rs2,
  input  logic [AW-1:0]   i_issue_rd,
  input  logic            i_issue_wen,
  output logic [XLEN-1:0] o_rdata1,
  output logic [XLEN-1:0] o_rdata2,
  input  logic            i_wb_valid,
  input  logic [AW-1:0]   i_wb_rd,
  input  logic [XLEN-1:0] i_wb_data,
  output logic [NREG-1:0] o_busy_vec,
  output logic [CW-1:0]   o_pending_cnt,
  output logic            o_wb_err
);
  logic [XLEN-1:0] r_gpr [NREG];
  logic [NREG-1:0] r_busy;
  logic [CW-1:0]   r_cnt;
  logic            r_err;
  logic            w_byp, w_rel1, w_rel2, w_reld, w_hz, w_fire, w_set, w_wb;
  logic [NREG-1:0] w_busy_nx;
  logic [CW-1:0]   w_cnt_nx;
  // A writeback in flight this cycle releases its register for the hazard check when forwarding is on.
  assign w_byp  = (BYPASS != 0) && i_wb_valid;
  assign w_rel1 = w_byp && (i_wb_rd == i_issue_rs1);
  assign w_rel2 = w_byp && (i_wb_rd == i_issue_rs2);
  assign w_reld = w_byp && (i_wb_rd == i_issue_rd);
  assign w_hz   = (r_busy[i_issue_rs1] && !w_rel1) || (r_busy[i_issue_rs2] && !w_rel2) ||
                  (i_issue_wen && (i_issue_rd != '0) && r_busy[i_issue_rd] && !w_reld);
  assign o_issue_ready = !rst && !w_hz;
  assign w_fire = i_issue_valid && o_issue_ready;
  assign w_set  = w_fire && i_issue_wen && (i_issue_rd != '0);
  assign w_wb   = i_wb_valid && (i_wb_rd != '0);
  assign o_rdata1 = (i_issue_rs1 == '0) ? '0 : w_rel1 ? i_wb_data : r_gpr[i_issue_rs1];
  assign o_rdata2 = (i_issue_rs2 == '0) ? '0 : w_rel2 ? i_wb_data : r_gpr[i_issue_rs2];
  assign o_busy_vec    = r_busy;
  assign o_pending_cnt = r_cnt;
  assign o_wb_err      = r_err;
  // Clear is applied before set so a same-cycle issue to the writeback target keeps the register busy.
  always_comb begin
    w_busy_nx = r_busy;
    if (w_wb) w_busy_nx[i_wb_rd] = 1'b0;
    if (w_set) w_busy_nx[i_issue_rd] = 1'b1;
    w_busy_nx[0] = 1'b0;
  end
  // Count is taken from the next busy vector so the registered count tracks busy_vec cycle for cycle.
  always_comb begin
    w_cnt_nx = '0;
    for (int i = 0; i < NREG; i++) w_cnt_nx = w_cnt_nx + CW'(w_busy_nx[i]);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) r_gpr[i] <= '0;
      r_busy <= '0;
      r_cnt  <= '0;
      r_err  <= 1'b0;
    end else begin
      if (w_wb) r_gpr[i_wb_rd] <= i_wb_data;
      if (w_wb && !r_busy[i_wb_rd]) r_err <= 1'b1;
      r_busy <= w_busy_nx;
      r_cnt  <= w_cnt_nx;
    end
  end
endmodule

// File: doc/ysyx_22040632_gpr_sb.md
YSYX_22040632_GPR_SB -- requirements
Module: ysyx_22040632_gpr_sb

Interface
REQ-001 Parameter XLEN, default 64, data width of every register and data port.
REQ-002 Parameter NREG, default 32, number of architectural registers; must be a power of two, >=2.
REQ-003 Parameter BYPASS, default 1, 1 = same-cycle writeback forwarding to read ports and issue check; 0 = none.
REQ-004 Localparam AW = clog2(NREG), register index width; CW = clog2(NREG+1), counter width.
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 rst  in  1  reset is synchronous and active-high.
REQ-007 issue_valid  in  1  decoder presents an instruction for issue.
REQ-008 issue_ready  out  1  block accepts the instruction this cycle.
REQ-009 issue_rs1, issue_rs2  in  AW each  source register indices.
REQ-010 issue_rd  in  AW  destination index.
REQ-011 issue_wen  in  1  instruction writes issue_rd.
REQ-012 rdata1, rdata2  out  XLEN each  source operand values, combinational.
REQ-013 wb_valid  in  1  writeback strobe.
REQ-014 wb_rd  in  AW  writeback destination.
REQ-015 wb_data  in  XLEN  writeback value.
REQ-016 busy_vec  out  NREG  per-register pending-write flags.
REQ-017 pending_cnt  out  CW  population count of busy_vec.
REQ-018 wb_err  out  1  sticky: writeback to a non-busy nonzero register observed.

Function
REQ-019 Register 0 reads as zero always; writes and busy-set to index 0 are discarded; busy_vec[0] is constantly 0.
REQ-020 Read port n: rdata = 0 if rs==0; else wb_data if BYPASS==1 and wb_valid and wb_rd==rs; else gpr[rs].
REQ-021 Register r is "released" this cycle when BYPASS==1, wb_valid and wb_rd==r.
REQ-022 Hazard: rs1 busy and not released (RAW), rs2 busy and not released (RAW), or issue_wen and rd!=0 and rd busy and not released (WAW).
REQ-023 issue_ready = !rst and no hazard; combinational; independent of issue_valid.
REQ-024 Issue fires on issue_valid && issue_ready at the rising edge; no internal buffering, no skid.
REQ-025 On fire with issue_wen and rd!=0: busy[rd] <= 1 next cycle.
REQ-026 On wb_valid and wb_rd!=0: gpr[wb_rd] <= wb_data and busy[wb_rd] <= 0, unless REQ-027 applies.
REQ-027 Same-cycle fire setting rd and writeback clearing the same rd: the data write happens, busy[rd] ends 1 (set wins).
REQ-028 wb_valid to wb_rd!=0 with busy[wb_rd]==0 (before update): data still written; wb_err <= 1, held until reset.
REQ-029 wb_valid with wb_rd==0: no state change, no error.
REQ-030 pending_cnt is registered and equals the popcount of busy_vec in the same cycle; range 0..NREG-1.
REQ-031 Without fire or writeback all state holds; latency from writeback to plain array read is one cycle, zero with BYPASS==1.

Reset
REQ-032 While rst is high at a rising edge: all gpr <= 0, busy_vec <= 0, pending_cnt <= 0, wb_err <= 0.
REQ-033 While rst is high issue_ready = 0; issue and writeback inputs are ignored, including mid-operation pending writes, which are dropped.
REQ-034 First edge with rst low operates normally; no post-reset warm-up cycles.

Verification
REQ-035 Reset then issue rd=5 wen=1 -> next cycle busy_vec[5]=1, pending_cnt=1; issue rs1=5 -> issue_ready=0.
REQ-036 BYPASS=1, busy[5]=1, wb_valid wb_rd=5 wb_data=0x1234 same cycle as issue rs1=5 -> issue_ready=1, rdata1=0x1234; next cycle busy[5]=0.
REQ-037 BYPASS=0, same stimulus -> issue_ready=0 that cycle; next cycle ready=1, rdata1=0x1234.
REQ-038 Same cycle: fire rd=7 and wb rd=7 data=0xAA (busy[7]=1 before) -> gpr[7]=0xAA, busy[7]=1, pending_cnt unchanged.
REQ-039 wb rd=0 data=0xFFFF -> rdata for rs=0 stays 0, wb_err=0; wb rd=3 with busy[3]=0 -> gpr[3] written, wb_err=1 sticky.
REQ-040 Three pending writes then rst high one cycle -> busy_vec=0, pending_cnt=0, all reads 0, issue_ready=0 during reset.
